// File: rtl/mw_pipe_pkg.sv
// Shared widths, state encoding and payload layout for the MEM->WB pipeline buffer.
// The default payload struct matches the default parameter widths.
package mw_pipe_pkg;

    localparam int DEF_CTRL_W        = 1;
    localparam int DEF_DATA_W        = 16;
    localparam int DEF_ADDR_W        = 3;
    localparam int DEF_CNT_W         = 16;
    localparam int CTRL_REGWRITE_BIT = 0;

    // Without the skid option only EMPTY and ONE (the FULL state) are reachable.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [DEF_CTRL_W-1:0] ctrl;
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_ADDR_W-1:0] addr;
    } mw_payload_t;

endpackage

// File: rtl/mw_buf_slot.sv
// One payload+valid holding register with load enable and synchronous clear.
// Loading an invalid entry zeroes the payload, so a bubble never carries stale data.
module mw_buf_slot #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic         d_valid,
    input  logic [W-1:0] d,
    output logic         q_valid,
    output logic [W-1:0] q
);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q       <= '0;
        end else if (clear) begin
            q_valid <= 1'b0;
            q       <= '0;
        end else if (load) begin
            q_valid <= d_valid;
            q       <= d_valid ? d : '0;
        end
    end

endmodule

// File: rtl/mw_pipe_buffer.sv
// MEM->WB pipeline register with valid/ready handshake, flush and saturating stall counter.
// Define MW_PIPE_BUF_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module mw_pipe_buffer
    import mw_pipe_pkg::*;
#(
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              wb_en,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int PW = CTRL_W + DATA_W + ADDR_W;

    buf_state_e    state;
    logic [PW-1:0] in_pl;
    logic [PW-1:0] main_d;
    logic [PW-1:0] main_q;
    logic          main_load;
    logic          main_dv;
    logic          main_v;

    assign in_pl = {in_ctrl, in_data, in_addr};

`ifdef MW_PIPE_BUF_SKID_EN
    logic          skid_v;
    logic [PW-1:0] skid_q;
    logic          skid_load;
    logic          skid_clear;
    logic          in_ready_q;

    assign in_ready = in_ready_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        main_load = 1'b0;
        main_d    = in_pl;
        main_dv   = in_valid;
        unique case (state)
            EMPTY: main_load = 1'b1;
            ONE:   main_load = out_ready;
            TWO: begin
                main_load = out_ready;
                main_d    = skid_q;
                main_dv   = 1'b1;
            end
            default: main_load = 1'b1;
        endcase
    end

    assign skid_load  = (state == ONE) && in_valid && !out_ready;
    assign skid_clear = flush || ((state == TWO) && out_ready);

    mw_buf_slot #(.W(PW)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (skid_clear),
        .load    (skid_load),
        .d_valid (in_valid),
        .d       (in_pl),
        .q_valid (skid_v),
        .q       (skid_q)
    );

    // in_ready is a registered FSM output, so out_ready never reaches it combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
        end else if (flush) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            unique case (state)
                EMPTY: if (in_valid) state <= ONE;
                ONE: begin
                    if (in_valid && !out_ready) begin
                        state      <= TWO;
                        in_ready_q <= 1'b0;
                    end else if (!in_valid && out_ready) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_ready) begin
                        state      <= ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end
`else
    assign in_ready  = (state == EMPTY) || out_ready;
    assign main_load = in_ready;
    assign main_d    = in_pl;
    assign main_dv   = in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else if (flush) begin
            state <= EMPTY;
        end else if (main_load) begin
            state <= in_valid ? ONE : EMPTY;
        end
    end
`endif

    mw_buf_slot #(.W(PW)) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (flush),
        .load    (main_load),
        .d_valid (main_dv),
        .d       (main_d),
        .q_valid (main_v),
        .q       (main_q)
    );

    assign out_valid                      = main_v;
    assign {out_ctrl, out_data, out_addr} = main_q;
    assign wb_en                          = main_v && out_ctrl[CTRL_REGWRITE_BIT];

    // Flush outranks a stall, and the counter holds at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mw_pipe_buffer.sv
// Directed, scoreboard-checked bench for mw_pipe_buffer (works with or without MW_PIPE_BUF_SKID_EN).
// A second instance with CNT_W=4 exercises stall counter saturation.
module tb_mw_pipe_buffer;
    import mw_pipe_pkg::*;

`ifdef MW_PIPE_BUF_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, in_valid, in_ready, out_valid, out_ready, wb_en;
    logic [0:0]  in_ctrl, out_ctrl;
    logic [15:0] in_data, out_data;
    logic [2:0]  in_addr, out_addr;
    logic [15:0] stall_cnt;

    logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_wb_en;
    logic [0:0]  s_in_ctrl, s_out_ctrl;
    logic [15:0] s_in_data, s_out_data;
    logic [2:0]  s_in_addr, s_out_addr;
    logic [3:0]  s_stall_cnt;

    always #5 clk = ~clk;

    mw_pipe_buffer dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_addr(in_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data), .out_addr(out_addr),
        .wb_en(wb_en), .stall_cnt(stall_cnt)
    );

    mw_pipe_buffer #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_ctrl(s_in_ctrl), .in_data(s_in_data), .in_addr(s_in_addr),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_ctrl(s_out_ctrl), .out_data(s_out_data), .out_addr(s_out_addr),
        .wb_en(s_wb_en), .stall_cnt(s_stall_cnt)
    );

    mw_payload_t sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        last_stalled = 1'b0;
    logic [15:0] last_data    = '0;
    logic        last_in_fire = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Samples handshakes at the falling edge, updates the scoreboard, then advances one cycle.
    task automatic tick();
        mw_payload_t exp;
        @(negedge clk);
        last_in_fire = 1'b0;
        if (last_stalled) check("hold_data", out_data, last_data);
        if (flush) begin
            sb.delete();
            last_stalled = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                check("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    exp = sb.pop_front();
                    check("sb_data",  out_data, exp.data);
                    check("sb_addr",  out_addr, exp.addr);
                    check("sb_ctrl",  out_ctrl, exp.ctrl);
                    check("sb_wb_en", wb_en,    exp.ctrl[0]);
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back('{ctrl: in_ctrl, data: in_data, addr: in_addr});
                last_in_fire = 1'b1;
            end
            last_stalled = out_valid && !out_ready;
            last_data    = out_data;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        int          idx;
        logic [15:0] s0;
        logic [15:0] s1;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_ctrl = '0; in_data = '0; in_addr = '0;
        s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1;
        s_in_ctrl = '0; s_in_data = '0; s_in_addr = '0;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_wb_en",     wb_en,     0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", in_ready, 1);

        // Single entry with reg-write, then a bubble.
        in_valid = 1'b1; in_ctrl = 1'b1; in_data = 16'h1234; in_addr = 3'd5;
        tick();
        in_valid = 1'b0;
        check("lat_out_valid", out_valid, 1);
        check("lat_out_data",  out_data,  16'h1234);
        check("lat_out_addr",  out_addr,  5);
        check("lat_wb_en",     wb_en,     1);
        tick();
        check("bubble_out_valid", out_valid, 0);
        check("bubble_out_data",  out_data,  0);

        // Entry without reg-write.
        in_valid = 1'b1; in_ctrl = 1'b0; in_data = 16'hbeef; in_addr = 3'd2;
        tick();
        in_valid = 1'b0;
        check("noreg_out_valid", out_valid, 1);
        check("noreg_wb_en",     wb_en,     0);
        tick();

        // Stream of 8 entries with out_ready low for cycles 3-5.
        idx = 0;
        s0  = stall_cnt;
        for (int c = 0; c < 60; c++) begin
            if (idx == 8 && sb.size() == 0 && !out_valid) break;
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (idx < 8);
            in_ctrl   = 1'(idx & 1);
            in_data   = 16'(16'hA000 + idx);
            in_addr   = 3'(idx);
            #1;
            if (c == 3) check("stream_in_ready_c3", in_ready, SKID ? 1 : 0);
            if (c == 4) check("stream_in_ready_c4", in_ready, 0);
            tick();
            if (last_in_fire) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_all_accepted", idx, 8);
        check("stream_sb_drained",   sb.size(), 0);
        check("stream_stall_cnt",    stall_cnt, 32'(s0 + 16'd3));

        // Fill under back-pressure, then flush with a new entry offered.
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 1'b1;
        in_data = 16'h1111; in_addr = 3'd1;
        tick();
        in_data = 16'h2222; in_addr = 3'd2;
        tick();
        check("full_in_ready", in_ready, 0);
        flush = 1'b1; in_data = 16'h3333; in_addr = 3'd3;
        s1 = stall_cnt;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("flush_out_valid", out_valid, 0);
        check("flush_out_data",  out_data,  0);
        check("flush_wb_en",     wb_en,     0);
        check("flush_in_ready",  in_ready,  1);
        check("flush_keeps_cnt", stall_cnt, 32'(s1));
        tick();
        check("flush_discard_valid", out_valid, 0);
        check("flush_discard_wb_en", wb_en,     0);

        // Saturation on the 4-bit counter instance.
        s_in_valid = 1'b1; s_in_ctrl = 1'b1; s_in_data = 16'h7777; s_in_addr = 3'd7;
        @(posedge clk); #1;
        s_in_valid = 1'b0; s_out_ready = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 10) check("sat_cnt_10", s_stall_cnt, 10);
        end
        check("sat_cnt_max",   s_stall_cnt, 15);
        check("sat_out_valid", s_out_valid, 1);
        check("sat_out_data",  s_out_data,  16'h7777);

        // Asynchronous reset while an entry is held and stalled.
        in_valid = 1'b1; in_ctrl = 1'b1; in_data = 16'h5555; in_addr = 3'd4; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("pre_rst_out_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_data",  out_data,  0);
        check("async_rst_stall_cnt", stall_cnt, 0);
        check("async_rst_wb_en",     wb_en,     0);
        sb.delete();
        last_stalled = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_in_ready",  in_ready,  1);
        check("rel_out_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
